alu_result_tx: RTL



---
 rtl/alu_tx_pkg.sv | 12 +
 rtl/alu_result_tx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_tx_pkg.sv
// Shared definitions for the ALU result serializer: state encoding and fixed widths.
package alu_tx_pkg;

  localparam int BYTE_W     = 8;
  localparam int DROP_CNT_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/alu_result_tx.sv
// Serializes registered ALU results LSB-byte-first onto a valid/ready byte stream,
// with one pending slot. Optional drop counter enabled by ALU_RESULT_TX_DROP_CNT_EN.
module alu_result_tx
  import alu_tx_pkg::*;
#(
  parameter  int OUT_WIDTH = 16,
  localparam int NUM_BYTES = OUT_WIDTH / BYTE_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  OUT_VALID,
  output logic [BYTE_W-1:0]     TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic                  DROP,
  output logic [DROP_CNT_W-1:0] DROP_CNT
);

  localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

  state_t                 state_reg, state_next;
  logic [OUT_WIDTH-1:0]   active_reg, active_next;
  logic [OUT_WIDTH-1:0]   pend_reg, pend_next;
  logic                   pend_full_reg, pend_full_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [BYTE_W-1:0]      tx_data_reg, tx_data_next;
  logic                   busy_reg, busy_next;
  logic                   drop_reg, drop_next;
  logic                   xfer;
  logic                   last_byte;

  // TX_VALID is exactly "in SEND", so a transfer is SEND && TX_READY.
  assign xfer      = (state_reg == SEND) && TX_READY;
  assign last_byte = (idx_reg == LAST_IDX);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg     <= IDLE;
      active_reg    <= '0;
      pend_reg      <= '0;
      pend_full_reg <= 1'b0;
      idx_reg       <= '0;
      tx_data_reg   <= '0;
      busy_reg      <= 1'b0;
      drop_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      active_reg    <= active_next;
      pend_reg      <= pend_next;
      pend_full_reg <= pend_full_next;
      idx_reg       <= idx_next;
      tx_data_reg   <= tx_data_next;
      busy_reg      <= busy_next;
      drop_reg      <= drop_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    active_next    = active_reg;
    pend_next      = pend_reg;
    pend_full_next = pend_full_reg;
    idx_next       = idx_reg;
    drop_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (OUT_VALID) begin
          active_next = ALU_OUT;
          idx_next    = '0;
          state_next  = SEND;
        end
      end
      SEND: begin
        if (xfer && last_byte) begin
          idx_next = '0;
          if (pend_full_reg) begin
            // Pending slot is promoted and can be refilled on the same edge.
            active_next    = pend_reg;
            pend_full_next = OUT_VALID;
            if (OUT_VALID) begin
              pend_next = ALU_OUT;
            end
          end else if (OUT_VALID) begin
            active_next = ALU_OUT;
          end else begin
            state_next = IDLE;
          end
        end else begin
          if (xfer) begin
            idx_next = idx_reg + IDX_W'(1);
          end
          if (OUT_VALID) begin
            if (!pend_full_reg) begin
              pend_next      = ALU_OUT;
              pend_full_next = 1'b1;
            end else begin
              drop_next = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output byte is pre-selected from next-state values so TX_DATA is a flop.
  always_comb begin
    tx_data_next = '0;
    if (state_next == SEND) begin
      tx_data_next = active_next[BYTE_W*int'(idx_next) +: BYTE_W];
    end
    busy_next = (state_next == SEND) | pend_full_next;
  end

  assign TX_DATA  = tx_data_reg;
  assign TX_VALID = (state_reg == SEND);
  assign BUSY     = busy_reg;
  assign DROP     = drop_reg;

`ifdef ALU_RESULT_TX_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt_reg;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      drop_cnt_reg <= '0;
    end else if (drop_next && (drop_cnt_reg != '1)) begin
      drop_cnt_reg <= drop_cnt_reg + DROP_CNT_W'(1);
    end
  end

  assign DROP_CNT = drop_cnt_reg;
`else
  assign DROP_CNT = '0;
`endif

endmodule
